// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner for HH:MM:SS, snapshotting disp_time once per frame.
// Optional: define DISP_BLANK_LZ_EN to blank the leading hours-tens digit when hours < 10.
module clock_display_scan #(
  parameter int unsigned DIGIT_HOLD     = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        kh_clk,
  input  logic        reset,
  input  logic [26:0] disp_time,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic        frame_start,
  output logic        err
);

  localparam logic [7:0] HOLD_LAST = 8'(DIGIT_HOLD - 1);
  localparam logic [6:0] SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0] AN_OFF    = AN_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic       DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [3:0] DASH_CODE = 4'd10;

  logic        run,      run_n;
  logic [7:0]  hold_cnt, hold_n;
  logic [2:0]  idx,      idx_n;
  logic [26:0] snap,     snap_n;
  logic        fs_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  an_n;
  logic        err_n;

  // Tens digit of a value below 64 by a compare chain.
  function automatic logic [2:0] tens_of(input logic [5:0] v);
    if      (v >= 6'd60) return 3'd6;
    else if (v >= 6'd50) return 3'd5;
    else if (v >= 6'd40) return 3'd4;
    else if (v >= 6'd30) return 3'd3;
    else if (v >= 6'd20) return 3'd2;
    else if (v >= 6'd10) return 3'd1;
    else                 return 3'd0;
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    logic [2:0] t;
    logic [5:0] u;
    t = tens_of(v);
    u = v - {t, 3'b000} - {2'b00, t, 1'b0};
    return u[3:0];
  endfunction

  // Active-high {g,f,e,d,c,b,a}; any code above 9 renders as a dash.
  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Scan sequencing: next idx/hold/snapshot.
  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    run_n  = 1'b1;
    hold_n = hold_cnt;
    idx_n  = idx;
    snap_n = snap;
    fs_n   = 1'b0;
    if (!run) begin
      hold_n = 8'd0;
      idx_n  = 3'd0;
      snap_n = disp_time;
      fs_n   = 1'b1;
    end else if (hold_cnt < HOLD_LAST) begin
      hold_n = hold_cnt + 8'd1;
    end else begin
      hold_n = 8'd0;
      if (idx == 3'd5) begin
        idx_n  = 3'd0;
        snap_n = disp_time;
        fs_n   = 1'b1;
      end else begin
        idx_n = idx + 3'd1;
      end
    end
  end

  // Output decode works on the post-edge idx/snapshot so registered outputs carry no extra lag.
  always_comb begin
    logic [4:0] hr;
    logic [5:0] mn, sc;
    logic [9:0] ms;
    logic       hr_bad, mn_bad, sc_bad, blank;
    logic [3:0] code;

    hr = snap_n[26:22];
    mn = snap_n[21:16];
    sc = snap_n[15:10];
    ms = snap_n[9:0];
    hr_bad = hr > 5'd23;
    mn_bad = mn > 6'd59;
    sc_bad = sc > 6'd59;
    blank  = 1'b0;
    code   = 4'd0;

    case (idx_n)
      3'd0:    code = sc_bad ? DASH_CODE : units_of(sc);
      3'd1:    code = sc_bad ? DASH_CODE : {1'b0, tens_of(sc)};
      3'd2:    code = mn_bad ? DASH_CODE : units_of(mn);
      3'd3:    code = mn_bad ? DASH_CODE : {1'b0, tens_of(mn)};
      3'd4:    code = hr_bad ? DASH_CODE : units_of({1'b0, hr});
      3'd5:    code = hr_bad ? DASH_CODE : {1'b0, tens_of({1'b0, hr})};
      default: code = 4'd0;
    endcase

`ifdef DISP_BLANK_LZ_EN
    blank = (idx_n == 3'd5) && !hr_bad && (hr < 5'd10);
`else
    blank = 1'b0;
`endif

    seg_n = blank ? SEG_OFF : (SEG_ACTIVE_LOW ? ~font(code) : font(code));
    dp_n  = ((idx_n == 3'd2 || idx_n == 3'd4) && ms < 10'd500) ? ~DP_OFF : DP_OFF;
    an_n  = AN_ACTIVE_LOW ? ~(6'b000001 << idx_n) : (6'b000001 << idx_n);
    err_n = hr_bad | mn_bad | sc_bad;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge kh_clk or negedge reset) begin
    if (!reset) begin
      run         <= 1'b0;
      hold_cnt    <= 8'd0;
      idx         <= 3'd0;
      snap        <= 27'd0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
      an          <= AN_OFF;
    end else begin
      run         <= run_n;
      hold_cnt    <= hold_n;
      idx         <= idx_n;
      snap        <= snap_n;
      frame_start <= fs_n;
      err         <= err_n;
      seg         <= seg_n;
      dp          <= dp_n;
      an          <= an_n;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan at default parameters (DIGIT_HOLD=2, active-low seg/an).
module tb_clock_display_scan;

  localparam int HOLD = 2;

  typedef int digits_t [6];

  logic        kh_clk = 1'b0;
  logic        reset;
  logic [26:0] disp_time;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        frame_start;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  // Active-high {g..a}: 0-9, 10 = dash, 11 = blank.
  localparam logic [6:0] FONT [12] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101,
    7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111, 7'b1000000, 7'b0000000
  };

  clock_display_scan #(
    .DIGIT_HOLD    (HOLD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .kh_clk     (kh_clk),
    .reset      (reset),
    .disp_time  (disp_time),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start),
    .err        (err)
  );

  always #5 kh_clk = ~kh_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [26:0] pack(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  // Checks one full frame from its first edge; loads next_time into disp_time after cycle change_at.
  task automatic check_frame(input string name, input digits_t d, input logic dp_on,
                             input logic exp_err, input int change_at,
                             input logic [26:0] next_time);
    logic [6:0] exp_seg;
    logic [5:0] exp_an;
    logic       exp_dp;
    int         k;
    for (int c = 0; c < 6 * HOLD; c++) begin
      @(posedge kh_clk);
      @(negedge kh_clk);
      k       = c / HOLD;
      exp_an  = ~(6'b000001 << k);
      exp_seg = ~FONT[d[k]];
      exp_dp  = !(dp_on && (k == 2 || k == 4));
      check($sformatf("%s an c%0d", name, c),  32'(an),  32'(exp_an));
      check($sformatf("%s seg c%0d", name, c), 32'(seg), 32'(exp_seg));
      check($sformatf("%s dp c%0d", name, c),  32'(dp),  32'(exp_dp));
      check($sformatf("%s fs c%0d", name, c),  32'(frame_start), (c == 0) ? 32'd1 : 32'd0);
      check($sformatf("%s err c%0d", name, c), 32'(err), 32'(exp_err));
      if (c == change_at) disp_time = next_time;
    end
  endtask

  initial begin
    digits_t d_lead;
    reset     = 1'b0;
    disp_time = pack(13, 45, 7, 250);
    repeat (10) @(posedge kh_clk);
    @(negedge kh_clk);
    check("reset an",  32'(an),  32'h3F);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp",  32'(dp),  32'd1);
    check("reset fs",  32'(frame_start), 32'd0);
    check("reset err", 32'(err), 32'd0);

    reset = 1'b1;
    check_frame("f1", '{7, 0, 5, 4, 3, 1}, 1'b1, 1'b0, 0, pack(13, 45, 7, 250));
    check_frame("f2_midchange", '{7, 0, 5, 4, 3, 1}, 1'b1, 1'b0, 6, pack(20, 0, 0, 0));
    check_frame("f3", '{0, 0, 0, 0, 0, 2}, 1'b1, 1'b0, 3, pack(20, 0, 0, 500));
    check_frame("f4_ms500", '{0, 0, 0, 0, 0, 2}, 1'b0, 1'b0, 3, pack(20, 0, 0, 499));
    check_frame("f5_ms499", '{0, 0, 0, 0, 0, 2}, 1'b1, 1'b0, 3, pack(24, 5, 0, 0));
    check_frame("f6_err", '{0, 0, 5, 0, 10, 10}, 1'b1, 1'b1, 3, pack(24, 5, 0, 0));

    // Advance into idx3 of the next frame, then drop reset between edges.
    repeat (7) begin
      @(posedge kh_clk);
      @(negedge kh_clk);
    end
    check("pre_reset an",  32'(an),  32'h37);
    check("pre_reset err", 32'(err), 32'd1);
    #2 reset = 1'b0;
    disp_time = pack(9, 30, 15, 100);
    #1;
    check("async an",  32'(an),  32'h3F);
    check("async seg", 32'(seg), 32'h7F);
    check("async dp",  32'(dp),  32'd1);
    check("async fs",  32'(frame_start), 32'd0);
    check("async err", 32'(err), 32'd0);
    @(negedge kh_clk);
    reset = 1'b1;

`ifdef DISP_BLANK_LZ_EN
    d_lead = '{5, 1, 0, 3, 9, 11};
`else
    d_lead = '{5, 1, 0, 3, 9, 0};
`endif
    check_frame("f7_after_reset", d_lead, 1'b1, 1'b0, 3, pack(9, 30, 15, 100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the 24-hour clock's packed `disp_time` bus. Drives a 6-digit multiplexed seven-segment display showing HH:MM:SS.
- Snapshots the time once per scan frame so a frame never mixes two different times (no tearing).
- Converts each binary field to two BCD digits and scans the digits one at a time, advancing on the kilohertz clock.
- Blinks the separator decimal points at 1 Hz using the millisecond field.

Parameters:
- DIGIT_HOLD, 2: `kh_clk` cycles each digit stays enabled; legal range 1..255.
- SEG_ACTIVE_LOW, 1: 1 = `seg`/`dp` lit when 0; 0 = lit when 1.
- AN_ACTIVE_LOW, 1: 1 = selected anode driven 0; 0 = driven 1.

Ports:
- kh_clk, input, 1: 1 kHz system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- disp_time, input, 27: packed as [26:22] hours 0-23, [21:16] minutes 0-59, [15:10] seconds 0-59, [9:0] milliseconds 0-999.
- seg, output, 7: segments {g,f,e,d,c,b,a} of the enabled digit.
- dp, output, 1: decimal point of the enabled digit.
- an, output, 6: one-hot digit enable; bit i = digit idx i.
- frame_start, output, 1: one-cycle pulse in the first cycle of every frame.
- err, output, 1: field of the current snapshot out of range.

Behaviour:
- Digit index mapping (idx): 0 sec units, 1 sec tens, 2 min units, 3 min tens, 4 hr units, 5 hr tens.
- State:
  - `run` flag.
  - `hold_cnt` (8 bit).
  - `idx` (3 bit, 0..5).
  - `snap` (27 bit).
- All outputs are registered.
- Reset asserted, asynchronously:
  - run=0, hold_cnt=0, idx=0, snap=0, frame_start=0, err=0.
  - All `an` inactive; `seg` and `dp` all unlit (with defaults: an=6'b111111, seg=7'h7F, dp=1).
- First edge after reset release:
  - run<=1, snap<=disp_time, idx<=0, hold_cnt<=0, frame_start<=1.
  - Outputs drive digit 0 of the new snapshot.
- Each later edge:
  - If hold_cnt<DIGIT_HOLD-1: hold_cnt++ and outputs hold.
  - Else hold_cnt<=0, and:
    - if idx<5: idx++;
    - if idx==5: idx<=0, snap<=disp_time, frame_start<=1.
  - frame_start is 0 on every other cycle.
- Outputs always decode the post-edge idx and snap; `an`, `seg` and `dp` change on the same edge. There is no blank cycle between digits.
- Frame length is 6*DIGIT_HOLD cycles. `disp_time` is ignored between snapshots.
- BCD conversion of fields below 64:
  - tens = count of 10s, via a compare/subtract chain; units = value - 10*tens.
  - Purely combinational from `snap`; no extra latency.
- Range check:
  - Fires if hours>23, minutes>59 or seconds>59; the offending pair shows a dash (segment g only) on both of its digits.
  - err = OR of the three checks on `snap`. Registered with the snapshot and held for the whole frame.
  - ms>999 is not checked.
- Segment font (active-high {g..a}): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, dash=1000000.
- dp is lit only on idx 2 and 4, and only when snap ms<500. It is unlit on all other digits.
- DIGIT_HOLD=1: idx advances every cycle; frame_start occurs every 6 cycles.

Optional Feature:
- Macro: DISP_BLANK_LZ_EN.
- Defined: when hours<10, the idx-5 digit shows all segments unlit while its anode is still enabled (a 9 h time reads " 9:MM:SS"). A dash on an out-of-range field takes precedence over blanking.
- Undefined: a leading zero is shown.
- Scan timing is identical with or without the macro.

Test Plan:
- Reset held low 10 cycles -> an=111111, seg=1111111, dp=1, frame_start=0, err=0 (all outputs at their reset values).
- disp_time={13,45,7,250}, defaults -> idx0..5 show 7,0,5,4,3,1 (e.g. idx0 seg=1111000, an=111110), each for 2 cycles; dp=0 on idx2 and idx4 only; frame_start every 12 cycles.
- disp_time changed to {20,0,0,0} at idx3 -> remaining digits still show 13:45:07; the new value appears only after the next frame_start.
- ms=500 -> dp=1 on all digits for the whole frame; ms=499 on the next frame -> dp=0 on idx2 and idx4.
- hours=24, minutes=5 -> err=1; idx4 and idx5 seg=0111111 (dash); minutes still show 0,5.
- reset pulled low during idx3 -> outputs blank immediately, without a clock edge. After release -> idx0 with a fresh snapshot and frame_start=1. With DISP_BLANK_LZ_EN and hours=9 -> idx5 seg=1111111 while its anode is enabled.
